// File: rtl/intpol2_d4_pkg.sv
// Shared definitions for the intpol2_D4 interpolator and its output FIFO.
// Holds the default sample width used by the core, the default FIFO sizing
// and a constant-evaluable clog2 for deriving address/level widths.
package intpol2_d4_pkg;

    localparam int DEFAULT_DATAPATH_WIDTH = 12;
    localparam int DEFAULT_DEPTH_LOG2     = 5;
    localparam int DEFAULT_AFULL_MARGIN   = 4;
    localparam int DEPTH                  = 2 ** DEFAULT_DEPTH_LOG2;
    localparam int LEVEL_WIDTH            = DEFAULT_DEPTH_LOG2 + 1;

    // Number of bits needed to represent values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/intpol2_d4_fifo_out_if.sv
// Write/read/status bundle of the intpol2_D4 output FIFO.
// master: producer/consumer side (core write strobe, consumer read request).
// slave:  the FIFO itself.
interface intpol2_d4_fifo_out_if #(
    parameter int DATAPATH_WIDTH = 12,
    parameter int LEVEL_WIDTH    = 6
);
    logic                      wr_en;
    logic [DATAPATH_WIDTH-1:0] din_I;
    logic [DATAPATH_WIDTH-1:0] din_Q;
    logic                      rd_en;
    logic [DATAPATH_WIDTH-1:0] dout_I;
    logic [DATAPATH_WIDTH-1:0] dout_Q;
    logic                      dout_valid;
    logic                      empty;
    logic                      full;
    logic                      afull;
    logic [LEVEL_WIDTH-1:0]    level;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output wr_en, din_I, din_Q, rd_en,
        input  dout_I, dout_Q, dout_valid, empty, full, afull, level,
               overflow, underflow
    );

    modport slave (
        input  wr_en, din_I, din_Q, rd_en,
        output dout_I, dout_Q, dout_valid, empty, full, afull, level,
               overflow, underflow
    );
endinterface

// File: rtl/intpol2_d4_fifo_mem.sv
// Simple dual-port storage for the output FIFO: synchronous write and a
// registered read port, shaped so it can be replaced by a BRAM macro.
// The array itself is never reset; only the read register is.
module intpol2_d4_fifo_mem
    import intpol2_d4_pkg::*;
#(
    parameter int WIDTH  = 2 * DEFAULT_DATAPATH_WIDTH,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; a same-cycle read of the same slot sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register: loads only on a read, otherwise holds the last word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/intpol2_d4_fifo_out.sv
// Dual-lane (I/Q) output FIFO downstream of the intpol2_D4 interpolator.
// Captures samples on the core write strobe, throttles the core via afull,
// and serves the consumer through a 1-cycle registered read port.
// Optional build macro: INTPOL2_FIFO_WATERMARK_EN adds the peak_level port.
module intpol2_d4_fifo_out
    import intpol2_d4_pkg::*;
#(
    parameter int DATAPATH_WIDTH = DEFAULT_DATAPATH_WIDTH,
    parameter int DEPTH_LOG2     = DEFAULT_DEPTH_LOG2,
    parameter int AFULL_MARGIN   = DEFAULT_AFULL_MARGIN
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clear,
    intpol2_d4_fifo_out_if.slave        bus
`ifdef INTPOL2_FIFO_WATERMARK_EN
    ,
    output logic [DEPTH_LOG2:0]         peak_level
`endif
);

    localparam int FIFO_DEPTH = 2 ** DEPTH_LOG2;
    localparam int LEVEL_W    = clog2(FIFO_DEPTH + 1);

    localparam logic [LEVEL_W-1:0] LEVEL_FULL  = LEVEL_W'(FIFO_DEPTH);
    localparam logic [LEVEL_W-1:0] LEVEL_AFULL = LEVEL_W'(FIFO_DEPTH - AFULL_MARGIN);

    logic [DEPTH_LOG2-1:0]       wr_ptr;
    logic [DEPTH_LOG2-1:0]       rd_ptr;
    logic [LEVEL_W-1:0]          level;
    logic [LEVEL_W-1:0]          level_next;
    logic                        dout_valid;
    logic                        overflow;
    logic                        underflow;
    logic                        empty;
    logic                        full;
    logic                        wr_acc;
    logic                        rd_acc;
    logic [2*DATAPATH_WIDTH-1:0] rd_data;

    assign empty = (level == '0);
    assign full  = (level == LEVEL_FULL);

    // Accept decisions; clear blocks both sides, and a read frees room for a write at full.
    always_comb begin
        rd_acc = bus.rd_en && !empty && !clear;
        wr_acc = bus.wr_en && (!full || rd_acc) && !clear;
    end

    // Next occupancy, used by the level register and the watermark.
    always_comb begin
        level_next = level;
        if (clear) begin
            level_next = '0;
        end else if (wr_acc && !rd_acc) begin
            level_next = level + LEVEL_W'(1);
        end else if (rd_acc && !wr_acc) begin
            level_next = level - LEVEL_W'(1);
        end
    end

    // Pointers, level, read-valid strobe and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            level      <= level_next;
            dout_valid <= rd_acc;
            if (clear) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                end
                if (bus.wr_en && !wr_acc) begin
                    overflow <= 1'b1;
                end
                if (bus.rd_en && !rd_acc) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

`ifdef INTPOL2_FIFO_WATERMARK_EN
    // Highest occupancy seen since the last reset or clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            peak_level <= '0;
        end else if (clear) begin
            peak_level <= '0;
        end else if (level_next > peak_level) begin
            peak_level <= level_next;
        end
    end
`endif

    intpol2_d4_fifo_mem #(
        .WIDTH  (2 * DATAPATH_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data ({bus.din_I, bus.din_Q}),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign bus.dout_I     = rd_data[2*DATAPATH_WIDTH-1:DATAPATH_WIDTH];
    assign bus.dout_Q     = rd_data[DATAPATH_WIDTH-1:0];
    assign bus.dout_valid = dout_valid;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.afull      = (level >= LEVEL_AFULL);
    assign bus.level      = level;
    assign bus.overflow   = overflow;
    assign bus.underflow  = underflow;

endmodule
